// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-backs onto one line-wide memory port.
// One transaction at a time: grant, wait for mem_ack, one-cycle completion ack, back to IDLE.
module mem_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_req_read,
  input  logic [WORD_SIZE-1:0]   i_addr,
  output logic                   i_ack,
  output logic [4*WORD_SIZE-1:0] i_rdata,
  input  logic                   d_req_read,
  input  logic [WORD_SIZE-1:0]   d_read_addr,
  input  logic                   d_req_write,
  input  logic [WORD_SIZE-1:0]   d_write_addr,
  input  logic [4*WORD_SIZE-1:0] d_wdata,
  output logic                   d_read_ack,
  output logic                   d_write_ack,
  output logic [4*WORD_SIZE-1:0] d_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [2:0]             state_o
);

  localparam int LW = 4 * WORD_SIZE;

  // Handshake: requesters hold req (and its address/data) until their ack pulse;
  // memory sees mem_req held with stable fields until the single-cycle mem_ack.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_I   = 3'd1,
    GNT_DWR = 3'd2,
    GNT_DRD = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  state_t                 state_q, state_d;
  state_t                 src_q;
  state_t                 grant_state;
  logic                   grant_en;
  logic                   done_en;
  logic                   d_pend;
  logic                   last_grant_q;
  logic [15:0]            i_grants_q;
  logic [15:0]            d_grants_q;
  logic                   i_ack_q, d_read_ack_q, d_write_ack_q;
  logic [LW-1:0]          i_rdata_q, d_rdata_q;
  logic                   mem_req_q, mem_we_q;
  logic [WORD_SIZE-1:0]   mem_addr_q;
  logic [LW-1:0]          mem_wdata_q;

  assign d_pend = d_req_write | d_req_read;

  always_comb begin
    state_d     = state_q;
    grant_en    = 1'b0;
    grant_state = GNT_I;
    done_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // I wins a tie only when D had the last grant.
        if (i_req_read && (!d_pend || last_grant_q == LG_D)) begin
          grant_en    = 1'b1;
          grant_state = GNT_I;
        end else if (d_pend) begin
          grant_en    = 1'b1;
          grant_state = d_req_write ? GNT_DWR : GNT_DRD;
        end
      end
      GNT_I, GNT_DWR, GNT_DRD: begin
        if (mem_ack) begin
          state_d = DONE;
          done_en = 1'b1;
        end
      end
      DONE: begin
        // A write-back is chained straight into its companion fill.
        if (src_q == GNT_DWR && d_req_read) begin
          grant_en    = 1'b1;
          grant_state = GNT_DRD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_en) state_d = grant_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      src_q         <= IDLE;
      last_grant_q  <= LG_D;
      i_grants_q    <= '0;
      d_grants_q    <= '0;
      i_ack_q       <= 1'b0;
      d_read_ack_q  <= 1'b0;
      d_write_ack_q <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      i_ack_q       <= 1'b0;
      d_read_ack_q  <= 1'b0;
      d_write_ack_q <= 1'b0;
      if (grant_en) begin
        mem_req_q <= 1'b1;
        unique case (grant_state)
          GNT_I: begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {i_addr[WORD_SIZE-1:2], 2'b00};
            mem_wdata_q  <= '0;
            last_grant_q <= LG_I;
            if (i_grants_q != 16'hFFFF) i_grants_q <= i_grants_q + 16'd1;
          end
          GNT_DWR: begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= {d_write_addr[WORD_SIZE-1:2], 2'b00};
            mem_wdata_q  <= d_wdata;
            last_grant_q <= LG_D;
            if (d_grants_q != 16'hFFFF) d_grants_q <= d_grants_q + 16'd1;
          end
          default: begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {d_read_addr[WORD_SIZE-1:2], 2'b00};
            mem_wdata_q  <= '0;
            last_grant_q <= LG_D;
            if (d_grants_q != 16'hFFFF) d_grants_q <= d_grants_q + 16'd1;
          end
        endcase
      end else if (done_en) begin
        mem_req_q   <= 1'b0;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= '0;
        mem_wdata_q <= '0;
        src_q       <= state_q;
        unique case (state_q)
          GNT_I: begin
            i_ack_q   <= 1'b1;
            i_rdata_q <= mem_rdata;
          end
          GNT_DWR: d_write_ack_q <= 1'b1;
          default: begin
            d_read_ack_q <= 1'b1;
            d_rdata_q    <= mem_rdata;
          end
        endcase
      end
    end
  end

  assign i_ack       = i_ack_q;
  assign i_rdata     = i_rdata_q;
  assign d_read_ack  = d_read_ack_q;
  assign d_write_ack = d_write_ack_q;
  assign d_rdata     = d_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder model, request/completion scoreboards, directed scenarios.
module tb_mem_arbiter;

  localparam logic [2:0] K_I   = 3'b001;
  localparam logic [2:0] K_DRD = 3'b010;
  localparam logic [2:0] K_DWR = 3'b100;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GNT_DRD = 3'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req_read = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_ack;
  logic [63:0] i_rdata;
  logic        d_req_read = 1'b0;
  logic [15:0] d_read_addr = '0;
  logic        d_req_write = 1'b0;
  logic [15:0] d_write_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_read_ack, d_write_ack;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic [2:0]  state_o;

  mem_arbiter #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_read(i_req_read), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req_read(d_req_read), .d_read_addr(d_read_addr),
    .d_req_write(d_req_write), .d_write_addr(d_write_addr), .d_wdata(d_wdata),
    .d_read_ack(d_read_ack), .d_write_ack(d_write_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat = 1;
  int stray_cnt = 0;
  int hold_err = 0;
  int reraise = 0;
  logic [15:0] reraise_addr = '0;
  logic [15:0] exp_ig = '0;
  logic [15:0] exp_dg = '0;
  logic [63:0] last_i_data = '0;
  logic [63:0] last_d_data = '0;

  // Scoreboards: memory requests {we, addr, wdata}, completions {onehot kind, data}
  logic [80:0] exp_mem_q[$];
  logic [80:0] obs_mem_q[$];
  logic [63:0] rdata_q[$];
  logic [66:0] exp_cpl_q[$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory responder: samples a new request, holds for mem_lat cycles, returns one ack pulse.
  initial begin
    int stray_seen;
    logic [80:0] first;
    stray_seen = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        mem_ack = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
      end else if (mem_req === 1'b1) begin
        first = {mem_we, mem_addr, mem_wdata};
        obs_mem_q.push_back(first);
        for (int k = 1; k < mem_lat; k++) begin
          @(negedge clk);
          if (reset_n && ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, first})) hold_err++;
        end
        mem_ack = 1'b1;
        mem_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 64'h0;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
  end

  task automatic push_req(input logic [2:0] kind, input logic [15:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata);
    logic is_wr;
    is_wr = (kind == K_DWR);
    exp_mem_q.push_back({is_wr, addr[15:2], 2'b00, (is_wr ? wdata : 64'h0)});
    rdata_q.push_back(rdata);
    exp_cpl_q.push_back({kind, (is_wr ? 64'h0 : rdata)});
    if (kind == K_I) begin
      if (exp_ig != 16'hFFFF) exp_ig++;
    end else begin
      if (exp_dg != 16'hFFFF) exp_dg++;
    end
  endtask

  // One negedge worth of scoreboard work plus requester behaviour (drop req on its ack).
  task automatic step();
    logic [80:0] o, e;
    logic [66:0] c;
    logic [2:0]  acks;
    while (obs_mem_q.size() > 0) begin
      o = obs_mem_q.pop_front();
      check("mem_req_expected", exp_mem_q.size() > 0, 1'b1);
      if (exp_mem_q.size() > 0) begin
        e = exp_mem_q.pop_front();
        check("mem_we_addr_wdata", o, e);
      end
    end
    acks = {d_write_ack, d_read_ack, i_ack};
    if (acks != 3'b000) begin
      check("ack_expected", exp_cpl_q.size() > 0, 1'b1);
      if (exp_cpl_q.size() > 0) begin
        c = exp_cpl_q.pop_front();
        check("ack_kind", acks, c[66:64]);
        if (c[66:64] == K_I) begin
          check("i_rdata", i_rdata, c[63:0]);
          last_i_data = c[63:0];
        end
        if (c[66:64] == K_DRD) begin
          check("d_rdata", d_rdata, c[63:0]);
          last_d_data = c[63:0];
        end
      end
      if (i_ack) begin
        if (reraise > 0) begin
          reraise--;
          i_addr = reraise_addr;
        end else begin
          i_req_read = 1'b0;
        end
      end
      if (d_read_ack) d_req_read = 1'b0;
      if (d_write_ack) d_req_write = 1'b0;
    end
  endtask

  task automatic run(input int budget);
    int cyc;
    cyc = 0;
    while (exp_cpl_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      step();
    end
    check("run_completions_left", exp_cpl_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    i_req_read = 1'b0;
    d_req_read = 1'b0;
    d_req_write = 1'b0;
    repeat (3) @(negedge clk);
    exp_mem_q.delete();
    obs_mem_q.delete();
    rdata_q.delete();
    exp_cpl_q.delete();
    exp_ig = '0;
    exp_dg = '0;
    last_i_data = '0;
    last_d_data = '0;
    check("rst_state", state_o, ST_IDLE);
    check("rst_mem_req", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    check("rst_acks", {i_ack, d_read_ack, d_write_ack}, 3'b000);
    check("rst_rdata", {i_rdata, d_rdata}, '0);
    check("rst_counters", {dut.i_grants_q, dut.d_grants_q}, '0);
    check("rst_last_grant_d", dut.last_grant_q, 1'b1);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] r;
    int cyc;

    // I-only fill, memory latency 3
    do_reset();
    mem_lat = 3;
    push_req(K_I, 16'h0123, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD);
    i_addr = 16'h0123;
    i_req_read = 1'b1;
    run(50);
    repeat (3) begin
      @(negedge clk);
      step();
    end
    check("ionly_i_rdata_hold", i_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    check("ionly_i_grants", dut.i_grants_q, 16'd1);
    check("ionly_state", state_o, ST_IDLE);

    // Tie from reset: I first, then I re-raises while D waits -> D, then I
    do_reset();
    mem_lat = 2;
    push_req(K_I,   16'h0200, 64'h0, 64'h0101_0202_0303_0404);
    push_req(K_DRD, 16'h0304, 64'h0, 64'h5555_6666_7777_8888);
    push_req(K_I,   16'h0408, 64'h0, 64'h9999_AAAA_BBBB_CCCC);
    i_addr = 16'h0200;
    d_read_addr = 16'h0304;
    reraise = 1;
    reraise_addr = 16'h0408;
    i_req_read = 1'b1;
    d_req_read = 1'b1;
    run(100);
    check("tie_i_grants", dut.i_grants_q, exp_ig);
    check("tie_d_grants", dut.d_grants_q, exp_dg);

    // Write-back + fill pair with I pending; last grant was I so D goes first
    mem_lat = 1;
    push_req(K_DWR, 16'h0040, 64'h1111_2222_3333_4444, 64'h0);
    push_req(K_DRD, 16'h0088, 64'h0, 64'hCAFE_0000_BABE_1111);
    push_req(K_I,   16'h0500, 64'h0, 64'h1234_5678_9ABC_DEF0);
    d_write_addr = 16'h0040;
    d_wdata = 64'h1111_2222_3333_4444;
    d_read_addr = 16'h0088;
    i_addr = 16'h0500;
    d_req_write = 1'b1;
    d_req_read = 1'b1;
    i_req_read = 1'b1;
    run(100);
    check("pair_d_grants", dut.d_grants_q, exp_dg);
    check("pair_d_rdata_hold", d_rdata, 64'hCAFE_0000_BABE_1111);

    // Stray mem_ack while idle
    repeat (2) @(negedge clk);
    stray_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stray_no_ack", {d_write_ack, d_read_ack, i_ack}, 3'b000);
      check("stray_state", state_o, ST_IDLE);
    end
    check("stray_i_rdata", i_rdata, last_i_data);
    check("stray_d_rdata", d_rdata, last_d_data);
    check("stray_counters", {dut.i_grants_q, dut.d_grants_q}, {exp_ig, exp_dg});

    // Back-to-back I fills, then preload near the top to exercise saturation
    for (int k = 0; k < 5; k++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      r = {$urandom(), $urandom()};
      push_req(K_I, a, 64'h0, r);
      i_addr = a;
      i_req_read = 1'b1;
      run(40);
      check("bb_i_grants", dut.i_grants_q, exp_ig);
    end
    @(negedge clk);
    force dut.i_grants_q = 16'hFFFC;
    @(negedge clk);
    release dut.i_grants_q;
    exp_ig = 16'hFFFC;
    check("sat_preload", dut.i_grants_q, exp_ig);
    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      r = {$urandom(), $urandom()};
      push_req(K_I, a, 64'h0, r);
      i_addr = a;
      i_req_read = 1'b1;
      run(40);
      check("sat_i_grants", dut.i_grants_q, exp_ig);
    end
    check("sat_final", dut.i_grants_q, 16'hFFFF);
    check("mem_hold_stable", hold_err, 0);
    check("mem_exp_drained", exp_mem_q.size(), 0);

    // Reset while in GNT_DRD; the late mem_ack must not produce d_read_ack
    repeat (3) @(negedge clk);
    mem_lat = 6;
    push_req(K_DRD, 16'h0100, 64'h0, 64'h7777_0000_7777_0000);
    d_read_addr = 16'h0100;
    d_req_read = 1'b1;
    cyc = 0;
    while (state_o != ST_GNT_DRD && cyc < 20) begin
      @(negedge clk);
      cyc++;
      step();
    end
    check("reach_gnt_drd", state_o, ST_GNT_DRD);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_state", state_o, ST_IDLE);
    check("async_rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    check("async_rst_acks", {i_ack, d_read_ack, d_write_ack}, 3'b000);
    check("async_rst_rdata", {i_rdata, d_rdata}, '0);
    check("async_rst_counters", {dut.i_grants_q, dut.d_grants_q}, '0);
    d_req_read = 1'b0;
    exp_cpl_q.delete();
    exp_mem_q.delete();
    obs_mem_q.delete();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("late_ack_ignored", {d_write_ack, d_read_ack, i_ack}, 3'b000);
      check("late_ack_state", state_o, ST_IDLE);
    end
    check("late_ack_d_rdata", d_rdata, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WORD_SIZE, 16, data and address word width; line width is fixed at 4*WORD_SIZE (64).
REQ-002 Single clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 i_req_read  in  1  I-cache line-fill request; held until i_ack.
REQ-006 i_addr  in  16  I-cache fill address.
REQ-007 i_ack  out  1  one-cycle I-fill completion pulse.
REQ-008 i_rdata  out  64  I-fill line data.
REQ-009 d_req_read  in  1  D-cache line-fill request; held until d_read_ack.
REQ-010 d_read_addr  in  16  D-cache fill address.
REQ-011 d_req_write  in  1  D-cache write-back request; held until d_write_ack.
REQ-012 d_write_addr  in  16  write-back address.
REQ-013 d_wdata  in  64  write-back line data.
REQ-014 d_read_ack / d_write_ack  out  1 each  one-cycle completion pulses.
REQ-015 d_rdata  out  64  D-fill line data.
REQ-016 mem_req / mem_we  out  1 each  memory request strobe; 1 = write.
REQ-017 mem_addr  out  16  line address to memory.
REQ-018 mem_wdata  out  64  write line data.
REQ-019 mem_rdata  in  64  read line data, valid with mem_ack.
REQ-020 mem_ack  in  1  one-cycle completion from memory, any latency >= 1 cycle.

Function
REQ-021 Shall use FSM states IDLE, GNT_I, GNT_DWR, GNT_DRD, DONE.
REQ-022 IDLE: sample requests each edge; when none are pending, remain in IDLE.
REQ-023 IDLE tie-break:
- d_req_write beats d_req_read within the D side.
- Between I and D, the side not equal to last_grant wins.
- A single pending side wins outright.
REQ-024 GNT_x: mem_req=1, with mem_we, mem_addr, mem_wdata driven from the granted requester.
- All four are held stable until the mem_ack edge.
REQ-025 mem_addr shall be {addr[15:2],2'b00}; mem_wdata shall be 0 for reads.
REQ-026 On mem_ack in GNT_I or GNT_DRD:
- Capture mem_rdata into i_rdata or d_rdata.
- Go to DONE and drop mem_req in that same edge.
REQ-027 In DONE, assert the matching ack for exactly one cycle, then return to IDLE.
- Minimum transaction: 1 grant cycle + 1 DONE cycle; the next grant is decided at the edge after DONE.
REQ-028 Write-back/fill pairing:
- When GNT_DWR completes and d_req_read is high at the DONE edge, go directly to GNT_DRD, ignoring i_req_read.
- d_write_ack still pulses during that DONE cycle.
REQ-029 last_grant shall update on entry to GNT_I (to I) or GNT_DWR/GNT_DRD (to D).
REQ-030 i_rdata and d_rdata shall hold their values until the next completion on their own side.
REQ-031 mem_ack outside a GNT state shall be ignored without any state change.
REQ-032 Requests that drop before their grant shall be ignored; requests that drop during a grant shall not abort the memory transaction.
REQ-033 Two 16-bit saturating counters, i_grants and d_grants, shall increment on each grant entry and stick at 16'hFFFF; they are internal and observable by the bench.

Reset
REQ-034 reset_n low shall immediately, without waiting for clk, force:
- state = IDLE, last_grant = D;
- all outputs and both counters = 0.
REQ-035 Reset mid-transaction shall abandon the transaction with no ack; a mem_ack arriving after reset shall be ignored.

Verification
REQ-036 Bench shall cover these directed scenarios:
- I only: i_addr=16'h0123, mem_ack 3 cycles after mem_req with rdata 64'hAAAA_BBBB_CCCC_DDDD -> mem_addr=16'h0120, mem_we=0; i_rdata holds that value; i_ack is one cycle; i_grants=1.
- Tie from reset: I and D reads raised together -> I granted first, then D; a second tie -> D then I alternation holds.
- D write-back + fill with I pending: d_write_addr=16'h0040, d_wdata=64'h1111_2222_3333_4444, d_read_addr=16'h0088 -> write (mem_we=1), then read at 16'h0088, then I; no I grant between the pair.
- Reset asserted while in GNT_DRD -> outputs 0 asynchronously; the late mem_ack produces no d_read_ack.
- 65536 back-to-back I fills -> i_grants saturates at 16'hFFFF.
- Stray mem_ack in IDLE -> no ack outputs and no state change.
